mag_timer: RTL and testbench

- Countdown timer and magnetron driver on the receiving side of the magnetron control block.
- Consumes the set/reset pulses produced by the control logic and drives mag_on.
- Counts cook time down in BCD minutes:seconds.
- Returns timer_done to the control logic, closing the loop.

---
 rtl/mag_timer.sv | 238 +++++++++++++++++++++++
 tb/tb_mag_timer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_timer.sv
// mag_timer: BCD minutes:seconds countdown that drives the magnetron enable.
// Optional MAG_TIMER_BEEP_EN adds a beep output pulsed for 3 seconds when the count expires.
module mag_timer #(
  parameter int TICK_DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set,
  input  logic       reset,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_min,
  input  logic [2:0] load_sec_t,
  input  logic [3:0] load_sec_u,
  output logic       mag_on,
  output logic       timer_done,
  output logic [3:0] disp_min,
  output logic [2:0] disp_sec_t,
  output logic [3:0] disp_sec_u
`ifdef MAG_TIMER_BEEP_EN
  ,
  output logic       beep
`endif
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READY   = 2'd1,
    ST_RUNNING = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [3:0]    min_r, min_s;
  logic [2:0]    sec_t_r, sec_t_s;
  logic [3:0]    sec_u_r, sec_u_s;
  logic [PW-1:0] presc_r, presc_s;
  logic          mag_on_r, mag_on_s;
  logic          done_r, done_s;

  logic [3:0]    dec_min_s;
  logic [2:0]    dec_sec_t_s;
  logic [3:0]    dec_sec_u_s;
  logic          dec_zero_s;
  logic [3:0]    ld_min_s;
  logic [2:0]    ld_sec_t_s;
  logic [3:0]    ld_sec_u_s;
  logic          ld_zero_s;

  function automatic logic [3:0] clamp_digit9(input logic [3:0] v);
    if (v > 4'd9) begin
      clamp_digit9 = 4'd9;
    end else begin
      clamp_digit9 = v;
    end
  endfunction

  function automatic logic [2:0] clamp_digit5(input logic [2:0] v);
    if (v > 3'd5) begin
      clamp_digit5 = 3'd5;
    end else begin
      clamp_digit5 = v;
    end
  endfunction

  // Clamped load digits and BCD decrement of the current time
  always_comb begin
    ld_min_s    = clamp_digit9(load_min);
    ld_sec_t_s  = clamp_digit5(load_sec_t);
    ld_sec_u_s  = clamp_digit9(load_sec_u);
    ld_zero_s   = (ld_min_s == 4'd0) && (ld_sec_t_s == 3'd0) && (ld_sec_u_s == 4'd0);
    dec_min_s   = min_r;
    dec_sec_t_s = sec_t_r;
    dec_sec_u_s = sec_u_r;
    if (sec_u_r != 4'd0) begin
      dec_sec_u_s = sec_u_r - 4'd1;
    end else begin
      dec_sec_u_s = 4'd9;
      if (sec_t_r != 3'd0) begin
        dec_sec_t_s = sec_t_r - 3'd1;
      end else begin
        dec_sec_t_s = 3'd5;
        dec_min_s   = min_r - 4'd1;
      end
    end
    dec_zero_s = (dec_min_s == 4'd0) && (dec_sec_t_s == 3'd0) && (dec_sec_u_s == 4'd0);
  end

  // Next-state logic; request priority is clr > reset > set > load
  always_comb begin
    state_s  = state_r;
    min_s    = min_r;
    sec_t_s  = sec_t_r;
    sec_u_s  = sec_u_r;
    presc_s  = presc_r;
    mag_on_s = mag_on_r;
    done_s   = done_r;
    if (clr) begin
      state_s  = ST_IDLE;
      min_s    = 4'd0;
      sec_t_s  = 3'd0;
      sec_u_s  = 4'd0;
      presc_s  = {PW{1'b0}};
      mag_on_s = 1'b0;
      done_s   = 1'b0;
    end else begin
      case (state_r)
        ST_RUNNING: begin
          if (reset) begin
            // Prescaler is held so a resume finishes the interrupted second
            state_s  = ST_READY;
            mag_on_s = 1'b0;
          end else if (presc_r == PW'(TICK_DIV - 1)) begin
            presc_s = {PW{1'b0}};
            min_s   = dec_min_s;
            sec_t_s = dec_sec_t_s;
            sec_u_s = dec_sec_u_s;
            if (dec_zero_s) begin
              state_s  = ST_DONE;
              mag_on_s = 1'b0;
              done_s   = 1'b1;
            end else begin
              state_s = ST_RUNNING;
            end
          end else begin
            presc_s = presc_r + PW'(1);
          end
        end
        ST_IDLE, ST_READY, ST_DONE: begin
          if (reset) begin
            state_s = state_r;
          end else if (set) begin
            if (state_r == ST_READY) begin
              state_s  = ST_RUNNING;
              mag_on_s = 1'b1;
            end else begin
              state_s = state_r;
            end
          end else if (load) begin
            // A fresh load zeroes the prescaler, so a new run starts on a whole second
            min_s   = ld_min_s;
            sec_t_s = ld_sec_t_s;
            sec_u_s = ld_sec_u_s;
            presc_s = {PW{1'b0}};
            done_s  = 1'b0;
            if (ld_zero_s) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_READY;
            end
          end else begin
            state_s = state_r;
          end
        end
        default: begin
          state_s  = ST_IDLE;
          min_s    = 4'd0;
          sec_t_s  = 3'd0;
          sec_u_s  = 4'd0;
          presc_s  = {PW{1'b0}};
          mag_on_s = 1'b0;
          done_s   = 1'b0;
        end
      endcase
    end
  end

  // State, time and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      min_r    <= 4'd0;
      sec_t_r  <= 3'd0;
      sec_u_r  <= 4'd0;
      presc_r  <= {PW{1'b0}};
      mag_on_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      min_r    <= min_s;
      sec_t_r  <= sec_t_s;
      sec_u_r  <= sec_u_s;
      presc_r  <= presc_s;
      mag_on_r <= mag_on_s;
      done_r   <= done_s;
    end
  end

  assign mag_on     = mag_on_r;
  assign timer_done = done_r;
  assign disp_min   = min_r;
  assign disp_sec_t = sec_t_r;
  assign disp_sec_u = sec_u_r;

`ifdef MAG_TIMER_BEEP_EN
  localparam int BW = $clog2(3 * TICK_DIV);

  logic [BW-1:0] bcnt_r, bcnt_s;
  logic          beep_r, beep_s;

  // Beep runs only while in DONE: starts on entry, drops when DONE is left
  always_comb begin
    beep_s = beep_r;
    bcnt_s = bcnt_r;
    if (state_s != ST_DONE) begin
      beep_s = 1'b0;
      bcnt_s = {BW{1'b0}};
    end else if (state_r != ST_DONE) begin
      beep_s = 1'b1;
      bcnt_s = BW'(3 * TICK_DIV - 1);
    end else if (beep_r) begin
      if (bcnt_r == {BW{1'b0}}) begin
        beep_s = 1'b0;
      end else begin
        bcnt_s = bcnt_r - BW'(1);
      end
    end else begin
      beep_s = 1'b0;
    end
  end

  // Beep registers
  always_ff @(posedge clk) begin
    if (rst) begin
      beep_r <= 1'b0;
      bcnt_r <= {BW{1'b0}};
    end else begin
      beep_r <= beep_s;
      bcnt_r <= bcnt_s;
    end
  end

  assign beep = beep_r;
`endif

endmodule

// File: tb/tb_mag_timer.sv
// Bench for mag_timer: directed scenarios plus randomized traffic checked against a
// seconds-based reference model.
module tb_mag_timer;

  localparam int TD = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1, set = 1'b0, reset = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_min = 4'd0, load_sec_u = 4'd0;
  logic [2:0] load_sec_t = 3'd0;
  logic       mag_on, timer_done;
  logic [3:0] disp_min, disp_sec_u;
  logic [2:0] disp_sec_t;
`ifdef MAG_TIMER_BEEP_EN
  logic       beep;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: remaining time in whole seconds
  int m_t = 0, m_pre = 0, m_beep = 0;
  bit m_run = 1'b0, m_done = 1'b0;

  mag_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .set(set), .reset(reset), .clr(clr), .load(load),
    .load_min(load_min), .load_sec_t(load_sec_t), .load_sec_u(load_sec_u),
    .mag_on(mag_on), .timer_done(timer_done),
    .disp_min(disp_min), .disp_sec_t(disp_sec_t), .disp_sec_u(disp_sec_u)
`ifdef MAG_TIMER_BEEP_EN
    , .beep(beep)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_step();
    int lm, lst, lsu;
    if (m_beep > 0) m_beep--;
    if (rst || clr) begin
      m_t = 0; m_run = 1'b0; m_done = 1'b0; m_pre = 0; m_beep = 0;
    end else if (m_run) begin
      if (reset) m_run = 1'b0;
      else if (m_pre == TD - 1) begin
        m_pre = 0;
        m_t--;
        if (m_t == 0) begin m_run = 1'b0; m_done = 1'b1; m_beep = 3 * TD; end
      end else m_pre++;
    end else if (reset) begin
      m_run = 1'b0;
    end else if (set) begin
      if (m_t != 0) m_run = 1'b1;
    end else if (load) begin
      lm  = (load_min > 9) ? 9 : int'(load_min);
      lst = (load_sec_t > 5) ? 5 : int'(load_sec_t);
      lsu = (load_sec_u > 9) ? 9 : int'(load_sec_u);
      m_t = lm * 60 + lst * 10 + lsu;
      m_done = 1'b0; m_pre = 0; m_beep = 0;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic do_load(input logic [3:0] m, input logic [2:0] st, input logic [3:0] su);
    load = 1'b1; load_min = m; load_sec_t = st; load_sec_u = su;
    step(1);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    checks++;
    if (mag_on !== 1'b0 || timer_done !== 1'b0 || {disp_min, disp_sec_t, disp_sec_u} !== 11'd0) begin
      failures++;
      $display("FAIL reset_state: got mag=%b done=%b %0d:%0d%0d, expected mag=0 done=0 0:00",
               mag_on, timer_done, disp_min, disp_sec_t, disp_sec_u);
    end
    set = 1'b1; step(1); set = 1'b0;
    checks++;
    if (mag_on !== 1'b0) begin
      failures++;
      $display("FAIL set_in_idle: got mag=%b, expected 0", mag_on);
    end
  endtask

  task automatic test_countdown();
    do_load(4'd0, 3'd0, 4'd3);
    set = 1'b1;
    step(1);
    checks++;
    if (mag_on !== 1'b1 || {disp_min, disp_sec_t, disp_sec_u} !== {4'd0, 3'd0, 4'd3}) begin
      failures++;
      $display("FAIL start: got mag=%b %0d:%0d%0d, expected mag=1 0:03", mag_on, disp_min, disp_sec_t, disp_sec_u);
    end
    for (int s = 2; s >= 0; s--) begin
      step(1);
      checks++;
      if (disp_sec_u !== 4'(s + 1)) begin
        failures++;
        $display("FAIL mid_second: got sec_u=%0d, expected %0d", disp_sec_u, s + 1);
      end
      step(1);
      checks++;
      if (disp_sec_u !== 4'(s) || mag_on !== (s != 0) || timer_done !== (s == 0)) begin
        failures++;
        $display("FAIL tick_%0d: got sec_u=%0d mag=%b done=%b, expected sec_u=%0d mag=%b done=%b",
                 s, disp_sec_u, mag_on, timer_done, s, s != 0, s == 0);
      end
    end
    set = 1'b0;
    step(3);
    checks++;
    if (timer_done !== 1'b1 || mag_on !== 1'b0) begin
      failures++;
      $display("FAIL done_hold: got done=%b mag=%b, expected done=1 mag=0", timer_done, mag_on);
    end
    do_load(4'd0, 3'd0, 4'd0);
    checks++;
    if (timer_done !== 1'b0) begin
      failures++;
      $display("FAIL load_clears_done: got done=%b, expected 0", timer_done);
    end
  endtask

  task automatic test_borrow();
    do_load(4'd1, 3'd0, 4'd0);
    set = 1'b1; step(1); set = 1'b0;
    step(2);
    checks++;
    if ({disp_min, disp_sec_t, disp_sec_u} !== {4'd0, 3'd5, 4'd9}) begin
      failures++;
      $display("FAIL borrow: got %0d:%0d%0d, expected 0:59", disp_min, disp_sec_t, disp_sec_u);
    end
    step(20);
    checks++;
    if ({disp_min, disp_sec_t, disp_sec_u} !== {4'd0, 3'd4, 4'd9} || mag_on !== 1'b1) begin
      failures++;
      $display("FAIL ten_ticks: got %0d:%0d%0d mag=%b, expected 0:49 mag=1", disp_min, disp_sec_t, disp_sec_u, mag_on);
    end
    clr = 1'b1; step(1); clr = 1'b0;
  endtask

  task automatic test_pause_resume();
    do_load(4'd0, 3'd0, 4'd5);
    set = 1'b1;
    step(6);
    reset = 1'b1;
    step(1);
    checks++;
    if (mag_on !== 1'b0 || disp_sec_u !== 4'd3) begin
      failures++;
      $display("FAIL pause: got mag=%b sec_u=%0d, expected mag=0 sec_u=3", mag_on, disp_sec_u);
    end
    step(3);
    checks++;
    if (mag_on !== 1'b0 || disp_sec_u !== 4'd3) begin
      failures++;
      $display("FAIL paused_hold: got mag=%b sec_u=%0d, expected mag=0 sec_u=3", mag_on, disp_sec_u);
    end
    reset = 1'b0;
    step(1);
    checks++;
    if (mag_on !== 1'b1 || disp_sec_u !== 4'd3) begin
      failures++;
      $display("FAIL resume: got mag=%b sec_u=%0d, expected mag=1 sec_u=3", mag_on, disp_sec_u);
    end
    step(1);
    checks++;
    if (disp_sec_u !== 4'd2) begin
      failures++;
      $display("FAIL partial_second: got sec_u=%0d, expected 2", disp_sec_u);
    end
    set = 1'b0;
    clr = 1'b1; step(1); clr = 1'b0;
  endtask

  task automatic test_clamp_clr();
    do_load(4'd9, 3'd7, 4'd5);
    checks++;
    if ({disp_min, disp_sec_t, disp_sec_u} !== {4'd9, 3'd5, 4'd5}) begin
      failures++;
      $display("FAIL clamp_sec_t: got %0d:%0d%0d, expected 9:55", disp_min, disp_sec_t, disp_sec_u);
    end
    do_load(4'd12, 3'd6, 4'd11);
    checks++;
    if ({disp_min, disp_sec_t, disp_sec_u} !== {4'd9, 3'd5, 4'd9}) begin
      failures++;
      $display("FAIL clamp_all: got %0d:%0d%0d, expected 9:59", disp_min, disp_sec_t, disp_sec_u);
    end
    set = 1'b1; step(1); set = 1'b0;
    do_load(4'd0, 3'd0, 4'd1);
    checks++;
    if ({disp_min, disp_sec_t, disp_sec_u} !== {4'd9, 3'd5, 4'd9} || mag_on !== 1'b1) begin
      failures++;
      $display("FAIL load_running: got %0d:%0d%0d mag=%b, expected 9:59 mag=1", disp_min, disp_sec_t, disp_sec_u, mag_on);
    end
    clr = 1'b1; step(1); clr = 1'b0;
    checks++;
    if ({disp_min, disp_sec_t, disp_sec_u} !== 11'd0 || mag_on !== 1'b0 || timer_done !== 1'b0) begin
      failures++;
      $display("FAIL clr_running: got %0d:%0d%0d mag=%b done=%b, expected 0:00 mag=0 done=0",
               disp_min, disp_sec_t, disp_sec_u, mag_on, timer_done);
    end
  endtask

`ifdef MAG_TIMER_BEEP_EN
  task automatic test_beep();
    do_load(4'd0, 3'd0, 4'd1);
    set = 1'b1; step(1); set = 1'b0;
    step(2);
    for (int i = 0; i < 3 * TD; i++) begin
      checks++;
      if (beep !== 1'b1 || timer_done !== 1'b1) begin
        failures++;
        $display("FAIL beep_on_%0d: got beep=%b done=%b, expected beep=1 done=1", i, beep, timer_done);
      end
      step(1);
    end
    checks++;
    if (beep !== 1'b0) begin
      failures++;
      $display("FAIL beep_off: got beep=%b, expected 0", beep);
    end
    do_load(4'd0, 3'd0, 4'd1);
    set = 1'b1; step(1); set = 1'b0;
    step(4);
    clr = 1'b1; step(1); clr = 1'b0;
    checks++;
    if (beep !== 1'b0 || timer_done !== 1'b0) begin
      failures++;
      $display("FAIL beep_clr: got beep=%b done=%b, expected 0 0", beep, timer_done);
    end
  endtask
`endif

  task automatic test_random();
    logic beep_obs;
    rst = 1'b1; step(1); rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom % 200) == 0;
      clr        = ($urandom % 60) == 0;
      reset      = ($urandom % 10) == 0;
      set        = ($urandom % 3) == 0;
      load       = ($urandom % 6) == 0;
      load_min   = (($urandom % 4) == 0) ? 4'($urandom % 16) : 4'd0;
      load_sec_t = (($urandom % 4) == 0) ? 3'($urandom % 8) : 3'd0;
      load_sec_u = 4'($urandom % 16);
      step(1);
`ifdef MAG_TIMER_BEEP_EN
      beep_obs = beep;
`else
      beep_obs = (m_beep > 0);
`endif
      checks++;
      if (disp_min !== 4'(m_t / 60) || disp_sec_t !== 3'((m_t % 60) / 10) || disp_sec_u !== 4'(m_t % 10)
          || mag_on !== m_run || timer_done !== m_done || beep_obs !== (m_beep > 0)) begin
        failures++;
        $display("FAIL random_%0d: got %0d:%0d%0d mag=%b done=%b beep=%b, expected %0d:%0d%0d mag=%b done=%b beep=%b",
                 n, disp_min, disp_sec_t, disp_sec_u, mag_on, timer_done, beep_obs,
                 m_t / 60, (m_t % 60) / 10, m_t % 10, m_run, m_done, m_beep > 0);
      end
    end
    rst = 1'b0; clr = 1'b0; reset = 1'b0; set = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_pause_resume();
    test_clamp_clr();
`ifdef MAG_TIMER_BEEP_EN
    test_beep();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
